// File: rtl/flag_cond_unit_pkg.sv
//==============================================================================
// Module   : flag_cond_unit_pkg
// Brief    : Status-bit indices and x86 tttn condition-code encodings.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package flag_cond_unit_pkg;

  localparam int STAT_W  = 7;

  localparam int STAT_CF = 0;
  localparam int STAT_PF = 1;
  localparam int STAT_ZF = 2;
  localparam int STAT_SF = 3;
  localparam int STAT_OF = 4;
  localparam int STAT_AF = 5;
  localparam int STAT_DF = 6;

  // Odd encodings are the complement of the even one below them.
  localparam logic [3:0] CC_O  = 4'h0;
  localparam logic [3:0] CC_NO = 4'h1;
  localparam logic [3:0] CC_B  = 4'h2;
  localparam logic [3:0] CC_AE = 4'h3;
  localparam logic [3:0] CC_E  = 4'h4;
  localparam logic [3:0] CC_NE = 4'h5;
  localparam logic [3:0] CC_BE = 4'h6;
  localparam logic [3:0] CC_A  = 4'h7;
  localparam logic [3:0] CC_S  = 4'h8;
  localparam logic [3:0] CC_NS = 4'h9;
  localparam logic [3:0] CC_P  = 4'hA;
  localparam logic [3:0] CC_NP = 4'hB;
  localparam logic [3:0] CC_L  = 4'hC;
  localparam logic [3:0] CC_GE = 4'hD;
  localparam logic [3:0] CC_LE = 4'hE;
  localparam logic [3:0] CC_G  = 4'hF;

endpackage

`default_nettype wire

// File: rtl/flag_cond_unit_cond_decode.sv
//==============================================================================
// Module   : cond_decode
// Brief    : Combinational tttn condition evaluator: (flags, cc) -> taken.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module cond_decode
  import flag_cond_unit_pkg::*;
(
  input  logic [STAT_W-1:0] flags,
  input  logic [3:0]        cc,
  output logic              taken
);

  logic w_base;

  always_comb begin
    w_base = 1'b0;
    case (cc[3:1])
      3'd0: w_base = flags[STAT_OF];
      3'd1: w_base = flags[STAT_CF];
      3'd2: w_base = flags[STAT_ZF];
      3'd3: w_base = flags[STAT_CF] | flags[STAT_ZF];
      3'd4: w_base = flags[STAT_SF];
      3'd5: w_base = flags[STAT_PF];
      3'd6: w_base = flags[STAT_SF] ^ flags[STAT_OF];
      3'd7: w_base = flags[STAT_ZF] | (flags[STAT_SF] ^ flags[STAT_OF]);
      default: w_base = 1'b0;
    endcase
  end

  assign taken = w_base ^ cc[0];

endmodule

`default_nettype wire

// File: rtl/flag_cond_unit.sv
//==============================================================================
// Module   : flag_cond_unit
// Brief    : Architectural flags register with registered condition-query
//            responses. Define FLAG_COND_FWD_EN to forward same-cycle writes.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module flag_cond_unit #(
  parameter int               STAT_W    = 7,
  parameter logic [STAT_W-1:0] RST_FLAGS = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [STAT_W-1:0] wr_status,
  input  logic [STAT_W-1:0] wr_mask,
  output logic              wr_ready,
  input  logic              df_set,
  input  logic              df_clr,
  input  logic              q_valid,
  input  logic [3:0]        q_cc,
  output logic              q_ready,
  output logic              r_valid,
  output logic              r_taken,
  input  logic              r_ready,
  output logic [STAT_W-1:0] flags
);

  import flag_cond_unit_pkg::*;

  logic [STAT_W-1:0] r_flags;
  logic [STAT_W-1:0] w_next_flags;
  logic [STAT_W-1:0] w_eval_flags;
  logic              r_rsp_valid;
  logic              r_rsp_taken;
  logic              w_slot_free;
  logic              w_q_fire;
  logic              w_taken;

  always_comb begin
    w_next_flags = r_flags;
    if (wr_valid) begin
      w_next_flags = (r_flags & ~wr_mask) | (wr_status & wr_mask);
    end
    // STD/CLD override whatever the masked write put in DF.
    if (df_set) begin
      w_next_flags[STAT_DF] = 1'b1;
    end else if (df_clr) begin
      w_next_flags[STAT_DF] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= RST_FLAGS;
    end else begin
      r_flags <= w_next_flags;
    end
  end

  assign w_slot_free = ~r_rsp_valid | r_ready;

`ifdef FLAG_COND_FWD_EN
  assign w_eval_flags = w_next_flags;
  assign q_ready      = w_slot_free;
`else
  // Without forwarding, a query in any flag-modifying cycle waits one cycle.
  assign w_eval_flags = r_flags;
  assign q_ready      = w_slot_free & ~(wr_valid | df_set | df_clr);
`endif

  assign w_q_fire = q_valid & q_ready;

  cond_decode u_cond_decode (
    .flags (w_eval_flags),
    .cc    (q_cc),
    .taken (w_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_taken <= 1'b0;
    end else if (w_q_fire) begin
      r_rsp_valid <= 1'b1;
      r_rsp_taken <= w_taken;
    end else if (r_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign wr_ready = 1'b1;
  assign r_valid  = r_rsp_valid;
  assign r_taken  = r_rsp_taken;
  assign flags    = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_flag_cond_unit.sv
//==============================================================================
// Module   : tb_flag_cond_unit
// Brief    : Directed self-checking bench for flag_cond_unit.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_flag_cond_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid;
  logic [6:0] wr_status;
  logic [6:0] wr_mask;
  logic       wr_ready;
  logic       df_set;
  logic       df_clr;
  logic       q_valid;
  logic [3:0] q_cc;
  logic       q_ready;
  logic       r_valid;
  logic       r_taken;
  logic       r_ready;
  logic [6:0] flags;

  int n_vec = 0;
  int n_err = 0;

  flag_cond_unit #(
    .STAT_W    (7),
    .RST_FLAGS (7'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_status (wr_status),
    .wr_mask   (wr_mask),
    .wr_ready  (wr_ready),
    .df_set    (df_set),
    .df_clr    (df_clr),
    .q_valid   (q_valid),
    .q_cc      (q_cc),
    .q_ready   (q_ready),
    .r_valid   (r_valid),
    .r_taken   (r_taken),
    .r_ready   (r_ready),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Load flags with a full-mask write; q_valid held low meanwhile.
  task automatic load_flags(input logic [6:0] val, input logic set_df, input logic clr_df);
    q_valid   = 1'b0;
    wr_valid  = 1'b1;
    wr_status = val;
    wr_mask   = 7'h7F;
    df_set    = set_df;
    df_clr    = clr_df;
    tick();
    wr_valid  = 1'b0;
    df_set    = 1'b0;
    df_clr    = 1'b0;
  endtask

  // Stream all 16 condition codes and compare against a hand-built table.
  task automatic sweep(input string tag, input logic [15:0] exp_tbl);
    logic [15:0] got;
    got     = '0;
    r_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      q_valid = 1'b1;
      q_cc    = i[3:0];
      tick();
      got[i]  = r_taken;
    end
    q_valid = 1'b0;
    tick();
    chk(tag, got, exp_tbl);
  endtask

  initial begin
    rst_n     = 1'b0;
    wr_valid  = 1'b0;
    wr_status = '0;
    wr_mask   = '0;
    df_set    = 1'b0;
    df_clr    = 1'b0;
    q_valid   = 1'b0;
    q_cc      = '0;
    r_ready   = 1'b0;

    #3;
    chk("reset_flags", {9'd0, flags}, 16'h0000);
    chk("reset_rvalid", {15'd0, r_valid}, 16'h0000);
    chk("reset_rtaken", {15'd0, r_taken}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("wr_ready", {15'd0, wr_ready}, 16'h0001);
    chk("q_ready_idle", {15'd0, q_ready}, 16'h0001);

    // Masked write: only ZF and CF commit.
    wr_valid  = 1'b1;
    wr_status = 7'h7F;
    wr_mask   = 7'h05;
    tick();
    wr_valid  = 1'b0;
    chk("masked_write", {9'd0, flags}, 16'h0005);

    q_valid = 1'b1;
    q_cc    = 4'h6;
    tick();
    chk("be_valid", {15'd0, r_valid}, 16'h0001);
    chk("be_taken", {15'd0, r_taken}, 16'h0001);
    q_cc    = 4'h7;
    r_ready = 1'b1;
    tick();
    chk("a_taken", {15'd0, r_taken}, 16'h0000);
    q_valid = 1'b0;
    tick();
    chk("drain_rvalid", {15'd0, r_valid}, 16'h0000);

    // Signed conditions.
    load_flags(7'h08, 1'b0, 1'b0);
    q_valid = 1'b1; q_cc = 4'hC; tick();
    chk("l_sf1_of0", {15'd0, r_taken}, 16'h0001);
    q_cc = 4'hD; tick();
    chk("ge_sf1_of0", {15'd0, r_taken}, 16'h0000);
    load_flags(7'h18, 1'b0, 1'b0);
    q_valid = 1'b1; q_cc = 4'hC; tick();
    chk("l_sf1_of1", {15'd0, r_taken}, 16'h0000);
    q_cc = 4'hD; tick();
    chk("ge_sf1_of1", {15'd0, r_taken}, 16'h0001);
    load_flags(7'h1C, 1'b0, 1'b0);
    q_valid = 1'b1; q_cc = 4'hE; tick();
    chk("le_zf1", {15'd0, r_taken}, 16'h0001);
    q_cc = 4'hF; tick();
    chk("g_zf1", {15'd0, r_taken}, 16'h0000);
    q_valid = 1'b0;
    tick();

    // Backpressure: E(1), NE(0), S(1) with r_ready low at first.
    r_ready = 1'b0;
    q_valid = 1'b1;
    q_cc    = 4'h4;
    tick();
    q_cc    = 4'h5;
    chk("bp_first_taken", {15'd0, r_taken}, 16'h0001);
    chk("bp_q_ready_low", {15'd0, q_ready}, 16'h0000);
    tick();
    tick();
    chk("bp_hold_valid", {15'd0, r_valid}, 16'h0001);
    chk("bp_hold_taken", {15'd0, r_taken}, 16'h0001);
    r_ready = 1'b1;
    #1;
    chk("bp_q_ready_high", {15'd0, q_ready}, 16'h0001);
    tick();
    chk("bp_second", {14'd0, r_valid, r_taken}, 16'h0002);
    q_cc = 4'h8;
    tick();
    chk("bp_third", {14'd0, r_valid, r_taken}, 16'h0003);
    q_valid = 1'b0;
    tick();
    chk("bp_empty", {15'd0, r_valid}, 16'h0000);

    // Same-cycle write (ZF 0 -> 1) and query cc=E.
    load_flags(7'h18, 1'b0, 1'b0);
    wr_valid  = 1'b1;
    wr_status = 7'h04;
    wr_mask   = 7'h04;
    q_valid   = 1'b1;
    q_cc      = 4'h4;
    #1;
`ifdef FLAG_COND_FWD_EN
    chk("fwd_q_ready", {15'd0, q_ready}, 16'h0001);
    tick();
    wr_valid = 1'b0;
    q_valid  = 1'b0;
    chk("fwd_resp", {14'd0, r_valid, r_taken}, 16'h0003);
`else
    chk("nofwd_q_stall", {15'd0, q_ready}, 16'h0000);
    tick();
    wr_valid = 1'b0;
    chk("nofwd_no_resp", {15'd0, r_valid}, 16'h0000);
    #1;
    chk("nofwd_q_ready", {15'd0, q_ready}, 16'h0001);
    tick();
    q_valid = 1'b0;
    chk("nofwd_resp", {14'd0, r_valid, r_taken}, 16'h0003);
`endif
    chk("sc_flags", {9'd0, flags}, 16'h001C);
    tick();

    // DF override: set beats clr and beats the masked write.
    wr_valid  = 1'b1;
    wr_status = 7'h00;
    wr_mask   = 7'h40;
    df_set    = 1'b1;
    df_clr    = 1'b1;
    tick();
    chk("df_set_wins", {9'd0, flags}, 16'h005C);
    df_set    = 1'b0;
    wr_valid  = 1'b0;
    tick();
    chk("df_clr", {9'd0, flags}, 16'h001C);
    df_clr    = 1'b0;

    // Full tttn sweeps; AF/DF toggling must not move any result.
    sweep("sweep_1c", 16'h6959);
    load_flags(7'h3C, 1'b1, 1'b0);
    chk("flags_7c", {9'd0, flags}, 16'h007C);
    sweep("sweep_7c", 16'h6959);
    load_flags(7'h23, 1'b1, 1'b0);
    sweep("sweep_63", 16'hA666);
    load_flags(7'h03, 1'b0, 1'b0);
    sweep("sweep_03", 16'hA666);

    // Reset while a response is pending.
    r_ready = 1'b0;
    q_valid = 1'b1;
    q_cc    = 4'h1;
    tick();
    chk("pre_rst_valid", {15'd0, r_valid}, 16'h0001);
    q_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {15'd0, r_valid}, 16'h0000);
    chk("async_rst_flags", {9'd0, flags}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_q_ready", {15'd0, q_ready}, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/flag_cond_unit.md
Name: flag_cond_unit

Overview:
- Architectural flags register and condition evaluator. It is the consumer end of the ALU status path.
- Commits masked 7-bit status writes from execute and feeds the registered flags back as the ALU's status_in.
- Answers x86 condition-code queries (Jcc/SETcc/CMOVcc, 4-bit tttn encoding) through a valid/ready request/response handshake with a registered response.

Parameters:
- STAT_W, 7, status width; bit order follows the STAT_* defines (CF, PF, ZF, SF, OF, AF, DF).
- RST_FLAGS, 7'b0, reset value of the flags register.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  status write request.
- wr_status  in  STAT_W  new flag values from the ALU.
- wr_mask  in  STAT_W  1 = commit this bit; 0 = keep the old value.
- wr_ready  out  1  write acceptance; constant 1.
- df_set  in  1  STD.
- df_clr  in  1  CLD.
- q_valid  in  1  condition query valid.
- q_cc  in  4  condition code tttn.
- q_ready  out  1  query accepted this cycle.
- r_valid  out  1  response valid.
- r_taken  out  1  condition result.
- r_ready  in  1  response consumed.
- flags  out  STAT_W  registered architectural flags.

Behaviour:
- Reset (asynchronous, on rst_n low): flags = RST_FLAGS, r_valid = 0, r_taken = 0. An in-flight response is dropped.
- Write fire = wr_valid. Next flags = (flags & ~wr_mask) | (wr_status & wr_mask). Latency is 1 cycle: flags shows the new value on the edge after fire.
- DF override: df_set forces the DF bit to 1 and df_clr forces it to 0, taking priority over wr_mask[DF]. If both are high, df_set wins.
- Query fire = q_valid & q_ready.
  - q_ready = ~r_valid | r_ready, a single-entry output register.
  - On fire, r_taken and r_valid=1 register on the next edge.
- Response hold: r_valid and r_taken hold stable until r_ready is high. If a response is consumed and no new query fires, r_valid drops to 0.
- Back-to-back queries (r_valid & r_ready & q_valid) sustain 1 response per cycle.
- Same-cycle write and query: the query evaluates against the post-write flags (forwarded next-flags, including the DF override).
- Condition table, where odd cc is the complement of the preceding even cc:
  - 0 O: OF
  - 2 B: CF
  - 4 E: ZF
  - 6 BE: CF|ZF
  - 8 S: SF
  - A P: PF
  - C L: SF^OF
  - E LE: ZF|(SF^OF)
- AF and DF never affect any condition.

Optional Feature:
- Macro: FLAG_COND_FWD_EN.
- Defined: same-cycle write forwarding exactly as described in Behaviour.
- Undefined:
  - No forwarding path. Queries evaluate against registered flags only.
  - q_ready = (~r_valid | r_ready) & ~(wr_valid | df_set | df_clr). A query in a write cycle stalls one cycle, then sees the committed flags.
  - Throughput drops only on write cycles.

Decomposition:
- Shared defines/package: STAT_* bit indices, STAT_W, CC_* 4-bit encodings (CC_O..CC_G).
- Sub-module cond_decode: combinational (flags, cc) -> taken, reusable by the CMOV/SETcc datapath.
- The top module holds the flags register, the DF override, the forwarding mux and the response register.

Test Plan:
- Reset mid-response: r_valid=1, then rst_n low -> r_valid=0 and flags=0 immediately (asynchronous); q_ready=1 after release.
- Masked write: flags=0, then wr_status=7'h7F with mask=ZF|CF -> next cycle only ZF and CF are 1; query cc=6 (BE) -> r_taken=1; cc=7 (A) -> r_taken=0.
- Signed conditions: SF=1, OF=0 -> cc=C (L) taken=1, cc=D (GE) taken=0. SF=1, OF=1 -> L=0, GE=1. ZF=1, SF=OF -> LE=1.
- Backpressure: 3 queries with r_ready low -> q_ready low after the first; r_taken held stable. r_ready high -> one response per cycle, in order, no loss.
- Same-cycle write and query: ZF=0, write ZF=1 plus query cc=4.
  - FWD_EN defined -> r_taken=1 next cycle.
  - FWD_EN undefined -> q_ready=0 that cycle, accepted the next, r_taken=1.
- DF: df_set and df_clr high together with wr_mask[DF]=1, wr_status[DF]=0 -> DF=1. cc=0..F results unaffected by DF/AF toggling.
